ifu_iccm_mem_bus: RTL
=====================

// Module: ifu_iccm_mem_bus
// PURPOSE
//  Parametrised, bank-interleaved ICCM array with a valid/ready request port and registered read response.
//  Adds byte/halfword writes via internal read-modify-write, since array rows are full-word-write only.
//  Adds misalignment error reporting. Sits between IFU fetch/DMA arbitration and the ICCM storage.
//  A read returns one full line: one word from every bank.
// PARAMETERS
//  NUM_BANKS   4     banks, power of 2 >= 2; line = NUM_BANKS words
//  BANK_DEPTH  1024  rows per bank, power of 2
//  WORD_W      32    bits per bank word, multiple of 8
//  ADDR_W      derived = log2(NUM_BANKS*BANK_DEPTH*WORD_W/8); byte address width
// PORTS
//  clk           in   1                   core clock
//  rst_l         in   1                   async active-low reset
//  clk_override  in   1                   force all bank clock enables on
//  scan_mode     in   1                   passed to rvoclkhdr
//  req_valid     in   1                   request present
//  req_ready     out  1                   request accepted when valid&ready
//  req_write     in   1                   1=write, 0=line read
//  req_addr      in   ADDR_W              byte address
//  req_size      in   2                   0=byte 1=half 2=word (writes only)
//  req_wdata     in   WORD_W              write data, right-justified
//  rsp_valid     out  1                   read line valid (1-cycle pulse)
//  rsp_rdata     out  NUM_BANKS*WORD_W    line, bank0 in LSBs; 0 when rsp_valid=0
//  err_valid     out  1                   misaligned write rejected (1-cycle pulse)
// BEHAVIOUR
//  Clocking/reset:
//   - Single clock; rst_l is asynchronous and active-low.
//   - Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, err_valid=0.
//   - Array contents are not reset.
//  Address decode:
//   - word = addr[ADDR_W-1:log2(WORD_W/8)]
//   - bank = word[log2(NUM_BANKS)-1:0]
//   - row  = word[MSB:log2(NUM_BANKS)]
//  Clock gating:
//   - One rvoclkhdr per bank.
//   - en = read accept | write/RMW to that bank | clk_override.
//   - A read enables all banks.
//  FSM, IDLE (req_ready=1):
//   - Read accepted in cycle N: all banks read at row. rsp_valid=1 and rsp_rdata=line in N+1.
//   - Word write (req_size=2, aligned): written to bank/row at the end of cycle N. No response.
//   - Byte/half write, aligned: target bank read at row in N. Latch bank/row/byte-offset/size/wdata. -> RMW.
//   - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no array access, err_valid=1 in N+1, stay IDLE.
//  FSM, RMW (req_ready=0, exactly one cycle):
//   - Merge the latched bytes into the array word at offset.
//   - Write the merged word back at the end of the cycle. -> IDLE.
//  Ordering and hazards:
//   - A read accepted the cycle after a write sees the written data. A word write lands that cycle; an RMW is completed while ready=0.
//   - Back-to-back reads give one rsp per cycle, throughput 1.
//   - Sub-word write throughput is 1 per 2 cycles.
//  Boundary conditions:
//   - req_valid=0 gives no access and no bank clock (unless clk_override).
//   - Requests in RMW are not accepted and must be held by the requester.
//   - Reset asserted during RMW: pending merge dropped, array unchanged, state=IDLE.
//   - Highest row/bank is addressable; there is no wrap; every address in 2^ADDR_W is in range.
//   - clk_override never causes a write.
// TESTING
//  1. Reset: rst_l=0 mid-run -> req_ready=1, rsp_valid=0, rsp_rdata=0, err_valid=0 immediately (async).
//  2. Word writes 0x11111111/0x22222222/0x33333333/0x44444444 to 0x0,0x4,0x8,0xC; read 0x0
//     -> rsp_valid next cycle, rsp_rdata=0x44444444_33333333_22222222_11111111.
//  3. Byte write 0xAB to 0x5 over 0x22222222 -> req_ready=0 one cycle; read 0x0 -> word1=0x2222AB22.
//  4. Half write 0xBEEF to 0x3 -> err_valid=1 one cycle, no ready drop; read shows word0 unchanged.
//  5. Reads back-to-back on rows 0,1,2 -> three consecutive rsp_valid cycles, correct lines in order.
//  6. Half write 0x1234 to 0xA, reset asserted in the RMW cycle, then release and read
//     -> word2 still 0x33333333.

Source files
------------

// File: rtl/ifu_iccm_mem_bus_if.sv
// ---------------------------------------------------------------------------
// ifu_iccm_mem_bus_if
//   Request/response bundle between the IFU fetch/DMA arbiter (master) and the
//   banked ICCM array (slave).
//
//   req_valid / req_ready  request handshake, accepted when both are high
//   req_write              1 = write, 0 = full-line read
//   req_addr               byte address
//   req_size               0 = byte, 1 = halfword, 2 = word (writes only)
//   req_wdata              write data, right-justified
//   rsp_valid / rsp_rdata  one-cycle read-line response, bank0 in the LSBs
//   err_valid              one-cycle pulse for a rejected misaligned write
// ---------------------------------------------------------------------------
interface ifu_iccm_mem_bus_if #(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 1024,
    parameter int WORD_W     = 32
);
    localparam int ADDR_W = $clog2(NUM_BANKS * BANK_DEPTH * WORD_W / 8);
    localparam int LINE_W = NUM_BANKS * WORD_W;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [LINE_W-1:0] rsp_rdata;
    logic              err_valid;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, err_valid
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, err_valid
    );
endinterface

// File: rtl/ifu_iccm_mem_bus.sv
// ---------------------------------------------------------------------------
// ifu_iccm_mem_bus
//   Bank-interleaved ICCM storage. A read returns a full line (one word from
//   every bank) one cycle after acceptance. Word writes go straight into the
//   array; byte/halfword writes take a read-modify-write pass because array
//   rows are full-word-write only. Misaligned writes are rejected with a
//   one-cycle err_valid pulse and never touch the array.
//
//   clk           core clock
//   rst_l         asynchronous active-low reset
//   clk_override  force every bank clock enable on (never causes a write)
//   scan_mode     forwarded to the per-bank clock headers
//   bus           slave side of ifu_iccm_mem_bus_if
//
//   WORD_W must be a multiple of 8 and at least 16 so a halfword fits a row.
// ---------------------------------------------------------------------------

// Per-bank clock header: the enable is captured by a latch that is
// transparent while clk is low, so the gated clock never glitches.
module rvoclkhdr (
    input  logic clk,
    input  logic en,
    input  logic scan_mode,
    output logic l1clk
);
    logic en_latch;

    always_latch begin
        if (!clk) begin
            en_latch = en | scan_mode;
        end
    end

    assign l1clk = clk & en_latch;
endmodule

module ifu_iccm_mem_bus #(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 1024,
    parameter int WORD_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   clk_override,
    input  logic                   scan_mode,
    ifu_iccm_mem_bus_if.slave      bus
);
    localparam int OFF_W  = $clog2(WORD_W / 8);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = $clog2(BANK_DEPTH);
    localparam int LINE_W = NUM_BANKS * WORD_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RMW  = 1'b1;

    // ---------------- state ----------------
    logic [0:0]        state_q,      state_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic              err_valid_q,  err_valid_d;
    logic [BANK_W-1:0] rmw_bank_q,   rmw_bank_d;
    logic [ROW_W-1:0]  rmw_row_q,    rmw_row_d;
    logic [OFF_W-1:0]  rmw_off_q,    rmw_off_d;
    logic              rmw_half_q,   rmw_half_d;
    logic [WORD_W-1:0] rmw_wdata_q,  rmw_wdata_d;

    // ---------------- address decode ----------------
    logic [OFF_W-1:0]  req_off;
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;

    assign req_off  = bus.req_addr[OFF_W-1:0];
    assign req_bank = bus.req_addr[OFF_W +: BANK_W];
    assign req_row  = bus.req_addr[OFF_W+BANK_W +: ROW_W];

    logic is_word;
    logic is_half;
    logic misaligned;
    logic idle;
    logic accept;
    logic rd_acc;
    logic wr_acc;
    logic word_wr;
    logic sub_wr;
    logic rmw_active;

    // Size 3 is treated like a full word.
    assign is_word    = bus.req_size[1];
    assign is_half    = (bus.req_size == 2'd1);
    assign misaligned = (is_half && req_off[0]) || (is_word && (req_off != '0));

    assign idle       = (state_q == ST_IDLE);
    assign rmw_active = (state_q == ST_RMW);
    assign accept     = idle && bus.req_valid;
    assign rd_acc     = accept && !bus.req_write;
    assign wr_acc     = accept && bus.req_write && !misaligned;
    assign word_wr    = wr_acc && is_word;
    assign sub_wr     = wr_acc && !is_word;

    // ---------------- read-modify-write merge ----------------
    logic [LINE_W-1:0] line_rdata;
    logic [WORD_W-1:0] rmw_old;
    logic [WORD_W-1:0] rmw_new;
    logic [WORD_W-1:0] rmw_bitmask;
    logic [WORD_W-1:0] rmw_merged;

    // The old word was captured into its bank's read register during the
    // accept cycle; nothing else can overwrite it while in RMW.
    always_comb begin
        rmw_old = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rmw_bank_q == BANK_W'(b)) begin
                rmw_old = line_rdata[b*WORD_W +: WORD_W];
            end
        end
        rmw_new     = rmw_wdata_q << {rmw_off_q, 3'b000};
        rmw_bitmask = '0;
        for (int i = 0; i < WORD_W / 8; i++) begin
            if ((OFF_W'(i) == rmw_off_q) ||
                (rmw_half_q && (OFF_W'(i) == rmw_off_q + OFF_W'(1)))) begin
                rmw_bitmask[i*8 +: 8] = 8'hFF;
            end
        end
        rmw_merged = (rmw_old & ~rmw_bitmask) | (rmw_new & rmw_bitmask);
    end

    // Shared write port selection: RMW write-back owns the array in RMW.
    logic [ROW_W-1:0]  wr_row;
    logic [WORD_W-1:0] wr_data;

    assign wr_row  = rmw_active ? rmw_row_q  : req_row;
    assign wr_data = rmw_active ? rmw_merged : bus.req_wdata;

    // ---------------- next state ----------------
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rd_acc;
        err_valid_d = accept && bus.req_write && misaligned;
        rmw_bank_d  = rmw_bank_q;
        rmw_row_d   = rmw_row_q;
        rmw_off_d   = rmw_off_q;
        rmw_half_d  = rmw_half_q;
        rmw_wdata_d = rmw_wdata_q;

        if (sub_wr) begin
            rmw_bank_d  = req_bank;
            rmw_row_d   = req_row;
            rmw_off_d   = req_off;
            rmw_half_d  = is_half;
            rmw_wdata_d = bus.req_wdata;
        end

        case (state_q)
            ST_IDLE: if (sub_wr) state_d = ST_RMW;
            ST_RMW:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            rmw_bank_q  <= '0;
            rmw_row_q   <= '0;
            rmw_off_q   <= '0;
            rmw_half_q  <= 1'b0;
            rmw_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            err_valid_q <= err_valid_d;
            rmw_bank_q  <= rmw_bank_d;
            rmw_row_q   <= rmw_row_d;
            rmw_off_q   <= rmw_off_d;
            rmw_half_q  <= rmw_half_d;
            rmw_wdata_q <= rmw_wdata_d;
        end
    end

    // ---------------- banks ----------------
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic              bank_rd_en;
            logic              bank_wr_en;
            logic              bank_clk;
            logic [WORD_W-1:0] mem [BANK_DEPTH];
            logic [WORD_W-1:0] rdata_q;

            // A line read touches every bank; a sub-word write only reads its
            // target bank to fetch the word being merged.
            assign bank_rd_en = rd_acc || (sub_wr && (req_bank == BANK_W'(gi)));
            assign bank_wr_en = (word_wr && (req_bank == BANK_W'(gi))) ||
                                (rmw_active && (rmw_bank_q == BANK_W'(gi)));

            rvoclkhdr u_clkhdr (
                .clk       (clk),
                .en        (bank_rd_en | bank_wr_en | clk_override),
                .scan_mode (scan_mode),
                .l1clk     (bank_clk)
            );

            // Enables are qualified inside so clk_override only ungates.
            always_ff @(posedge bank_clk) begin
                if (bank_wr_en) begin
                    mem[wr_row] <= wr_data;
                end
                if (bank_rd_en) begin
                    rdata_q <= mem[req_row];
                end
            end

            assign line_rdata[gi*WORD_W +: WORD_W] = rdata_q;
        end
    endgenerate

    // ---------------- outputs ----------------
    assign bus.req_ready = idle;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_valid_q ? line_rdata : '0;
    assign bus.err_valid = err_valid_q;
endmodule
